// File: rtl/rpn_tokenizer.sv
// rpn_tokenizer
//   Front end of the stream calculator. Takes a byte-serial ASCII stream in
//   reverse-Polish form and turns it into single-cycle command pulses for the
//   calculator core. Decimal literals are accumulated digit by digit. Each
//   completed number becomes a push command (op=5). Each operator character
//   becomes one arithmetic command.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   char_valid  char holds a byte to consume
//   char[7:0]   ASCII byte
//   char_ready  byte accepted this cycle when char_valid is also high
//   apply       one-cycle command strobe to the core
//   in[W-1:0]   number to push (meaningful when apply=1 and op=5)
//   op[2:0]     0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 push
//   err         sticky error flag, cleared only by rst
//
// Configuration macro
//   RPN_OVF_CHECK_EN  when defined, a digit step that exceeds 2^W-1
//                     saturates the accumulator and sets err. When undefined,
//                     the accumulator wraps modulo 2^W silently.
module rpn_tokenizer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         char_valid,
  input  logic [7:0]   char,
  output logic         char_ready,
  output logic         apply,
  output logic [W-1:0] in,
  output logic [2:0]   op,
  output logic         err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NUM   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [2:0] OP_PUSH = 3'd5;

  logic [1:0]   state;
  logic [W-1:0] acc;
  logic [2:0]   pend_op;

  logic         accept;
  logic         is_digit;
  logic         is_sep;
  logic         is_op;
  logic [2:0]   op_code;
  logic [W-1:0] digit_ext;
  logic [W-1:0] acc_step;
  logic         step_ovf;

  // While FLUSH issues the latched operator, no byte can be taken.
  assign char_ready = (state != FLUSH);
  assign accept     = char_valid & char_ready;

  assign is_digit  = (char >= 8'h30) && (char <= 8'h39);
  assign is_sep    = (char == 8'h20) || (char == 8'h0A);
  assign digit_ext = {{(W-4){1'b0}}, char[3:0]};

  always_comb begin
    is_op   = 1'b1;
    op_code = 3'd0;
    case (char)
      8'h2B:   op_code = 3'd0;
      8'h2D:   op_code = 3'd1;
      8'h2A:   op_code = 3'd2;
      8'h2F:   op_code = 3'd3;
      8'h25:   op_code = 3'd4;
      default: is_op   = 1'b0;
    endcase
  end

  // acc*10 + d is formed as (acc<<3)+(acc<<1)+d. In the checked build the
  // four extra top bits reveal overflow. In the plain build the W-bit sum
  // wraps modulo 2^W.
`ifdef RPN_OVF_CHECK_EN
  logic [W+3:0] wide;
  assign wide     = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{W{1'b0}}, char[3:0]};
  assign step_ovf = |wide[W+3:W];
  assign acc_step = step_ovf ? {W{1'b1}} : wide[W-1:0];
`else
  assign step_ovf = 1'b0;
  assign acc_step = (acc << 3) + (acc << 1) + digit_ext;
`endif

  // A FLUSH cycle always emits the pending operator and returns to IDLE.
  // Otherwise, an accepted byte is decoded against the current state.
  // apply defaults low, so every command is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      pend_op <= 3'd0;
      apply   <= 1'b0;
      in      <= '0;
      op      <= OP_PUSH;
      err     <= 1'b0;
    end else begin
      apply <= 1'b0;
      if (state == FLUSH) begin
        apply <= 1'b1;
        op    <= pend_op;
        state <= IDLE;
      end else if (accept) begin
        if (is_digit) begin
          if (state == IDLE) begin
            acc   <= digit_ext;
            state <= NUM;
          end else begin
            acc <= acc_step;
            if (step_ovf) err <= 1'b1;
          end
        end else if (is_sep) begin
          if (state == NUM) begin
            apply <= 1'b1;
            op    <= OP_PUSH;
            in    <= acc;
            state <= IDLE;
          end
        end else if (is_op) begin
          if (state == NUM) begin
            apply   <= 1'b1;
            op      <= OP_PUSH;
            in      <= acc;
            pend_op <= op_code;
            state   <= FLUSH;
          end else begin
            apply <= 1'b1;
            op    <= op_code;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rpn_tokenizer.sv
// tb_rpn_tokenizer
//   Self-checking bench for rpn_tokenizer (W=8). A behavioural model tracks
//   the pending literal as a plain integer value plus a pending-operator flag.
//   It predicts char_ready, apply, op, in and err every cycle. Directed
//   streams are followed by randomized token streams with random valid gaps.
//   Honours RPN_OVF_CHECK_EN the same way the design does.
module tb_rpn_tokenizer;

  localparam int    W    = 8;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         char_valid;
  logic [7:0]   char;
  logic         char_ready;
  logic         apply;
  logic [W-1:0] in;
  logic [2:0]   op;
  logic         err;

  int tests_run;
  int fail_count;

  // Model state: the literal in progress as an unbounded integer.
  bit     m_have_num;
  longint m_val;
  bit     m_flush;
  int     m_flush_op;
  bit     m_err;
  bit     m_apply;
  int     m_op;
  longint m_in;

  rpn_tokenizer #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char       (char),
    .char_ready (char_ready),
    .apply      (apply),
    .in         (in),
    .op         (op),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int opCodeOf(input logic [7:0] c);
    case (c)
      8'h2B:   return 0;
      8'h2D:   return 1;
      8'h2A:   return 2;
      8'h2F:   return 3;
      8'h25:   return 4;
      default: return -1;
    endcase
  endfunction

  function automatic void modelReset();
    m_have_num = 0;
    m_val      = 0;
    m_flush    = 0;
    m_flush_op = 0;
    m_err      = 0;
    m_apply    = 0;
    m_op       = 5;
    m_in       = 0;
  endfunction

  // The pushed value is the literal reduced to W bits. It wraps modulo 2^W
  // or clamps at 2^W-1 when the overflow check is built in.
  function automatic void modelPush();
    m_apply = 1;
    m_op    = 5;
`ifdef RPN_OVF_CHECK_EN
    m_in = (m_val > MAXV) ? MAXV : m_val;
`else
    m_in = m_val % (MAXV + 1);
`endif
    m_have_num = 0;
  endfunction

  function automatic void modelEdge(input bit v, input logic [7:0] c);
    int code;
    m_apply = 0;
    if (m_flush) begin
      m_apply = 1;
      m_op    = m_flush_op;
      m_flush = 0;
    end else if (v) begin
      code = opCodeOf(c);
      if (c >= "0" && c <= "9") begin
        m_val      = m_have_num ? m_val * 10 + longint'(c - "0") : longint'(c - "0");
        m_have_num = 1;
`ifdef RPN_OVF_CHECK_EN
        if (m_val > MAXV) m_err = 1;
`endif
      end else if (c == 8'h20 || c == 8'h0A) begin
        if (m_have_num) modelPush();
      end else if (code >= 0) begin
        if (m_have_num) begin
          modelPush();
          m_flush    = 1;
          m_flush_op = code;
        end else begin
          m_apply = 1;
          m_op    = code;
        end
      end else begin
        m_err = 1;
      end
    end
  endfunction

  // One clock cycle: drive on the falling edge, check readiness there, then
  // check the registered outputs just after the rising edge.
  task automatic stepCycle(input bit v, input logic [7:0] c, output bit taken);
    @(negedge clk);
    char_valid = v;
    char       = c;
    checkOutput("char_ready", {31'd0, char_ready}, {31'd0, !m_flush});
    taken = v && !m_flush;
    @(posedge clk);
    modelEdge(v, c);
    #1;
    checkOutput("apply", {31'd0, apply}, {31'd0, m_apply});
    checkOutput("op", {29'd0, op}, m_op);
    checkOutput("in", {24'd0, in}, m_in[31:0]);
    checkOutput("err", {31'd0, err}, {31'd0, m_err});
  endtask

  // mode 0: valid held high; mode 1: idle cycle before each byte;
  // mode 2: random idle cycles.
  task automatic applyStimulus(input string s, input int mode);
    bit   taken;
    int   tries;
    logic [7:0] ch;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0))
        stepCycle(1'b0, 8'($urandom_range(0, 255)), taken);
      tries = 0;
      taken = 0;
      while (!taken && tries < 4) begin
        stepCycle(1'b1, ch, taken);
        tries++;
      end
      if (!taken) checkOutput("handshake_timeout", 32'd0, 32'd1);
    end
    char_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    bit taken;
    for (int i = 0; i < n; i++) stepCycle(1'b0, 8'h00, taken);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst        = 1'b1;
    char_valid = 1'b0;
    #1;
    checkOutput("rst_apply", {31'd0, apply}, 32'd0);
    checkOutput("rst_in", {24'd0, in}, 32'd0);
    checkOutput("rst_op", {29'd0, op}, 32'd5);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_ready", {31'd0, char_ready}, 32'd1);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic string randomToken(input bit junk_en);
    string ops;
    string tok;
    int    r;
    int    k;
    ops = "+-*/%";
    tok = "";
    r   = $urandom_range(0, 9);
    if (r <= 5) begin
      k = $urandom_range(1, 4);
      for (int d = 0; d < k; d++) begin
        tok = {tok, $sformatf("%0d", $urandom_range(0, 9))};
        if (junk_en && $urandom_range(0, 7) == 0) tok = {tok, "x"};
      end
      r = $urandom_range(0, 6);
      if (r == 0)      tok = {tok, " "};
      else if (r == 1) tok = {tok, "\n"};
      else             tok = {tok, $sformatf("%c", ops[r-2])};
    end else if (r <= 7) begin
      tok = $sformatf("%c", ops[$urandom_range(0, 4)]);
    end else if (r == 8 || !junk_en) begin
      tok = " ";
    end else begin
      tok = "#";
    end
    return tok;
  endfunction

  initial begin
    tests_run  = 0;
    fail_count = 0;
    rst        = 1'b1;
    char_valid = 1'b0;
    char       = 8'h00;
    modelReset();

    doReset();
    applyStimulus("12 3+", 0);
    idleCycles(2);
    checkOutput("plus_op", {29'd0, op}, 32'd0);

    doReset();
    applyStimulus("25%", 0);
    idleCycles(2);
    checkOutput("mod_op", {29'd0, op}, 32'd4);
    checkOutput("mod_in", {24'd0, in}, 32'd25);

    doReset();
    applyStimulus("7x ", 0);
    idleCycles(3);
    checkOutput("err_sticky", {31'd0, err}, 32'd1);
    checkOutput("junk_push", {24'd0, in}, 32'd7);

    doReset();
    applyStimulus("300 ", 0);
`ifdef RPN_OVF_CHECK_EN
    checkOutput("ovf_in", {24'd0, in}, 32'd255);
    checkOutput("ovf_err", {31'd0, err}, 32'd1);
`else
    checkOutput("ovf_in", {24'd0, in}, 32'd44);
    checkOutput("ovf_err", {31'd0, err}, 32'd0);
`endif

    doReset();
    applyStimulus("45", 0);
    doReset();
    applyStimulus("6 ", 0);
    checkOutput("post_rst_in", {24'd0, in}, 32'd6);

    doReset();
    applyStimulus("9 ", 1);
    idleCycles(2);
    checkOutput("toggle_in", {24'd0, in}, 32'd9);

    // Random streams, first without and then with junk bytes, so that err is
    // exercised both clear and set.
    doReset();
    for (int t = 0; t < 150; t++) applyStimulus(randomToken(1'b0), 2);
    idleCycles(2);
    doReset();
    for (int t = 0; t < 150; t++) applyStimulus(randomToken(1'b1), 2);
    idleCycles(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
